// File: rtl/generator_seq_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed generator network.
// Helpers work on the widest supported word (MAX_W) so any WIDTH up to 64 can use them.
package generator_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    L2_MAC = 3'd1,
    L2_WB  = 3'd2,
    L3_MAC = 3'd3,
    L3_WB  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;
  localparam int MAX_W     = 64;
  localparam int MAX_ACC   = 2 * MAX_W + 4;

  // Accumulator width: full product plus headroom for the bias and a few additions.
  function automatic int acc_width(input int width);
    return 2 * width + 4;
  endfunction

  localparam int ACC_W = 2 * DEF_WIDTH + 4;
  localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1) << DEF_FRAC;

  // acc >>> frac, then either wrap to the low width bits or clamp to the signed width range.
  function automatic logic signed [MAX_W-1:0] requant(
    input logic signed [MAX_ACC-1:0] acc,
    input int                        frac,
    input int                        width,
    input bit                        sat
  );
    logic signed [MAX_ACC-1:0] sh;
    logic signed [MAX_ACC-1:0] hi;
    logic signed [MAX_ACC-1:0] lo;
    logic signed [MAX_ACC-1:0] res;
    sh  = acc >>> frac;
    hi  = $signed((MAX_ACC'(1) << (width - 1)) - MAX_ACC'(1));
    lo  = ~hi;
    res = (sh <<< (MAX_ACC - width)) >>> (MAX_ACC - width);
    if (sat && (sh > hi)) begin
      res = hi;
    end else if (sat && (sh < lo)) begin
      res = lo;
    end
    return MAX_W'(res);
  endfunction

  function automatic logic signed [MAX_W-1:0] relu(input logic signed [MAX_W-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/generator_seq_if.sv
// Start/done request bus between the latent-vector source (master) and generator_seq (slave).
interface generator_seq_if #(
  parameter int WIDTH   = 32,
  parameter int N_INPUT = 2,
  parameter int N_L2    = 3,
  parameter int N_L3    = 9
);
  // Handshake: start is taken on a rising edge only while busy is low (IDLE or DONE);
  // a_in is captured on that edge, weights/biases must then hold until done, which
  // pulses for one cycle and marks y valid until the next done.
  logic                         start;
  logic [N_INPUT*WIDTH-1:0]     a_in;
  logic [N_INPUT*N_L2*WIDTH-1:0] w_L2;
  logic [N_L2*WIDTH-1:0]        b_L2;
  logic [N_L2*N_L3*WIDTH-1:0]   w_L3;
  logic [N_L3*WIDTH-1:0]        b_L3;
  logic                         busy;
  logic                         done;
  logic [N_L3*WIDTH-1:0]        y;

  modport master (output start, a_in, w_L2, b_L2, w_L3, b_L3, input busy, done, y);
  modport slave  (input start, a_in, w_L2, b_L2, w_L3, b_L3, output busy, done, y);
endinterface

// File: rtl/generator_seq_mac_unit.sv
// Single signed MAC with bias preload and requantised output.
// GENERATOR_SEQ_SAT_EN selects saturating requantisation instead of two's-complement wrap.
module mac_unit
  import generator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_bias,
  input  logic                    acc_en,
  input  logic signed [WIDTH-1:0] bias,
  input  logic signed [WIDTH-1:0] op_a,
  input  logic signed [WIDTH-1:0] op_b,
  output logic signed [WIDTH-1:0] q
);
  localparam int AW = acc_width(WIDTH);

`ifdef GENERATOR_SEQ_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic signed [AW-1:0]      acc_q;
  logic signed [AW-1:0]      acc_d;
  logic signed [2*WIDTH-1:0] prod;

  always_comb begin
    prod  = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
    acc_d = acc_q;
    if (load_bias) begin
      acc_d = AW'(bias) <<< FRAC;
    end else if (acc_en) begin
      acc_d = acc_q + AW'(prod);
    end
    q = WIDTH'(requant(MAX_ACC'(acc_q), FRAC, WIDTH, SAT_EN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/generator_seq.sv
// Sequential 2-layer dense generator (ReLU hidden layer, linear output) on one shared MAC.
// Output requantisation mode is chosen by GENERATOR_SEQ_SAT_EN inside mac_unit.
module generator_seq
  import generator_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 16,
  parameter int N_INPUT = 2,
  parameter int N_L2    = 3,
  parameter int N_L3    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  generator_seq_if.slave    bus,
  output state_t            dbg_state
);
  localparam int N_MAX = (N_INPUT > N_L2) ? ((N_INPUT > N_L3) ? N_INPUT : N_L3)
                                          : ((N_L2 > N_L3) ? N_L2 : N_L3);
  localparam int CW = $clog2(N_MAX + 1);
  localparam logic [CW-1:0] T2_LAST = CW'(N_INPUT - 1);
  localparam logic [CW-1:0] N2_LAST = CW'(N_L2 - 1);
  localparam logic [CW-1:0] T3_LAST = CW'(N_L2 - 1);
  localparam logic [CW-1:0] N3_LAST = CW'(N_L3 - 1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            term_q, term_d;
  logic [CW-1:0]            neur_q, neur_d;
  logic [N_INPUT*WIDTH-1:0] a_q, a_d;
  logic [N_L2*WIDTH-1:0]    h_q, h_d;
  logic [N_L3*WIDTH-1:0]    buf_q, buf_d;
  logic [N_L3*WIDTH-1:0]    y_q, y_d;

  logic                     load_bias, acc_en;
  logic signed [WIDTH-1:0]  bias, op_a, op_b, q;

  mac_unit #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_bias (load_bias),
    .acc_en    (acc_en),
    .bias      (bias),
    .op_a      (op_a),
    .op_b      (op_b),
    .q         (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      term_q  <= '0;
      neur_q  <= '0;
      a_q     <= '0;
      h_q     <= '0;
      buf_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      neur_q  <= neur_d;
      a_q     <= a_d;
      h_q     <= h_d;
      buf_q   <= buf_d;
      y_q     <= y_d;
    end
  end

  always_comb begin : ns_comb
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = L2_MAC;
      L2_MAC:  if (term_q == T2_LAST) state_d = L2_WB;
      L2_WB:   state_d = (neur_q == N2_LAST) ? L3_MAC : L2_MAC;
      L3_MAC:  if (term_q == T3_LAST) state_d = L3_WB;
      L3_WB:   state_d = (neur_q == N3_LAST) ? DONE : L3_MAC;
      DONE:    state_d = bus.start ? L2_MAC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, operand muxes and write-back. Each WB edge also preloads the next neuron's bias.
  always_comb begin : dp_comb
    term_d    = term_q;
    neur_d    = neur_q;
    a_d       = a_q;
    h_d       = h_q;
    buf_d     = buf_q;
    y_d       = y_q;
    load_bias = 1'b0;
    acc_en    = 1'b0;
    op_a      = '0;
    op_b      = '0;
    bias      = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d       = bus.a_in;
          term_d    = '0;
          neur_d    = '0;
          load_bias = 1'b1;
          bias      = bus.b_L2[0 +: WIDTH];
        end
      end
      L2_MAC: begin
        acc_en = 1'b1;
        op_a   = a_q[int'(term_q)*WIDTH +: WIDTH];
        op_b   = bus.w_L2[(N_INPUT*int'(neur_q) + int'(term_q))*WIDTH +: WIDTH];
        term_d = (term_q == T2_LAST) ? '0 : term_q + CW'(1);
      end
      L2_WB: begin
        h_d[int'(neur_q)*WIDTH +: WIDTH] = WIDTH'(relu(MAX_W'(q)));
        term_d    = '0;
        load_bias = 1'b1;
        if (neur_q == N2_LAST) begin
          neur_d = '0;
          bias   = bus.b_L3[0 +: WIDTH];
        end else begin
          neur_d = neur_q + CW'(1);
          bias   = bus.b_L2[(int'(neur_q) + 1)*WIDTH +: WIDTH];
        end
      end
      L3_MAC: begin
        acc_en = 1'b1;
        op_a   = h_q[int'(term_q)*WIDTH +: WIDTH];
        op_b   = bus.w_L3[(N_L2*int'(neur_q) + int'(term_q))*WIDTH +: WIDTH];
        term_d = (term_q == T3_LAST) ? '0 : term_q + CW'(1);
      end
      L3_WB: begin
        buf_d[int'(neur_q)*WIDTH +: WIDTH] = q;
        term_d = '0;
        if (neur_q == N3_LAST) begin
          // y only ever takes a complete buffer, so it is valid in the DONE cycle.
          neur_d = '0;
          y_d    = buf_d;
        end else begin
          neur_d    = neur_q + CW'(1);
          load_bias = 1'b1;
          bias      = bus.b_L3[(int'(neur_q) + 1)*WIDTH +: WIDTH];
        end
      end
      default: begin
        term_d = '0;
      end
    endcase
  end

  always_comb begin : out_comb
    bus.busy  = (state_q != IDLE) && (state_q != DONE);
    bus.done  = (state_q == DONE);
    bus.y     = y_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_generator_seq.sv
// Directed bench for generator_seq: default-size instance plus a small non-default instance.
module tb_generator_seq;
  import generator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  generator_seq_if #(.WIDTH(32), .N_INPUT(2), .N_L2(3), .N_L3(9)) bus ();
  generator_seq_if #(.WIDTH(32), .N_INPUT(4), .N_L2(2), .N_L3(5)) bus2 ();
  state_t dbg1, dbg2;

  generator_seq #(.WIDTH(32), .FRAC(16), .N_INPUT(2), .N_L2(3), .N_L3(9)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg1)
  );
  generator_seq #(.WIDTH(32), .FRAC(16), .N_INPUT(4), .N_L2(2), .N_L3(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(dbg2)
  );

  localparam logic [31:0] F1  = 32'h0001_0000;
  localparam logic [31:0] F2  = 32'h0002_0000;
  localparam logic [31:0] F9  = 32'h0009_0000;
  localparam logic [31:0] FM1 = 32'hFFFF_0000;
  localparam logic [31:0] FH  = 32'h0000_8000;
  localparam logic [31:0] BIG = 32'h7FFF_0000;
`ifdef GENERATOR_SEQ_SAT_EN
  localparam logic [31:0] OVF_Y = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_Y = 32'hFFFA_0000;
`endif

  int vecs = 0;
  int miss = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set1(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wl2,
                      input logic [31:0] bl2, input logic [31:0] wl3, input logic [31:0] bl3);
    bus.a_in = {a1, a0};
    for (int i = 0; i < 6; i++)  bus.w_L2[i*32 +: 32] = wl2;
    for (int i = 0; i < 3; i++)  bus.b_L2[i*32 +: 32] = bl2;
    for (int i = 0; i < 27; i++) bus.w_L3[i*32 +: 32] = wl3;
    for (int i = 0; i < 9; i++)  bus.b_L3[i*32 +: 32] = bl3;
  endtask

  task automatic chk_y1(input string tag, input logic [31:0] exp);
    for (int j = 0; j < 9; j++) chk($sformatf("%s_y%0d", tag, j), 64'(bus.y[j*32 +: 32]), 64'(exp));
  endtask

  // One evaluation on the default instance; a_in is scrambled after accept to prove it was latched.
  task automatic run1(input string tag, input logic [31:0] exp_y);
    logic [63:0] a_save;
    int cyc;
    int busy_low;
    a_save    = bus.a_in;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a_in  = 64'hDEAD_BEEF_1234_5678;
    cyc       = 1;
    busy_low  = 0;
    chk({tag, "_busy_c1"}, 64'(bus.busy), 64'd1);
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy !== 1'b1) busy_low++;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd46);
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_busy_gaps"}, 64'(busy_low), 64'd0);
    chk_y1(tag, exp_y);
    tick();
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    bus.a_in = a_save;
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    set1(F1, F2, F1, 32'h0, F1, 32'h0);
    bus2.start = 1'b0;
    for (int i = 0; i < 4; i++)  bus2.a_in[i*32 +: 32] = F1;
    for (int i = 0; i < 8; i++)  bus2.w_L2[i*32 +: 32] = FH;
    for (int i = 0; i < 2; i++)  bus2.b_L2[i*32 +: 32] = 32'h0;
    for (int i = 0; i < 10; i++) bus2.w_L3[i*32 +: 32] = FH;
    for (int i = 0; i < 5; i++)  bus2.b_L3[i*32 +: 32] = 32'h0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_y", 64'(bus.y[63:0]), 64'd0);
    chk("rst_state", 64'(dbg1), 64'(IDLE));
    rst_n = 1'b1;
    tick();

    // Basic evaluation: hidden = 3.0, outputs = 9.0
    run1("basic", F9);

    // Negative hidden weights: ReLU clamps, outputs equal the 0.5 bias
    set1(F1, F2, FM1, 32'h0, F1, FH);
    run1("relu", FH);

    // start held high: back-to-back evaluations, done only at 46 and 92
    set1(F1, F2, F1, 32'h0, F1, 32'h0);
    bus.start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      chk($sformatf("held_done_c%0d", c), 64'(bus.done), 64'((c == 46 || c == 92) ? 1 : 0));
      chk($sformatf("held_y0_c%0d", c), 64'(bus.y[31:0]), 64'((c < 46) ? FH : F9));
    end
    bus.start = 1'b0;
    chk_y1("held", F9);
    cyc = 100;
    while (bus.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("held_third_done_cycle", 64'(cyc), 64'd138);
    tick();

    // Overflow: saturate or wrap depending on build
    set1(BIG, BIG, BIG, 32'h0, BIG, 32'h0);
    run1("ovf", OVF_Y);

    // Reset mid-evaluation at cycle 20
    set1(F1, F2, F1, 32'h0, F1, 32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    chk("midrst_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk_y1("midrst", 32'h0);
    chk("midrst_state", 64'(dbg1), 64'(IDLE));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run1("post_rst", F9);

    // Non-default sizes: hidden = 2.0, outputs = 2.0, latency 26
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    cyc = 1;
    while (bus2.done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("small_latency", 64'(cyc), 64'd26);
    for (int j = 0; j < 5; j++) chk($sformatf("small_y%0d", j), 64'(bus2.y[j*32 +: 32]), 64'(F2));
    tick();
    chk("small_state_idle", 64'(dbg2), 64'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
